// File: rtl/exc_ctrl.sv
// MEM-stage exception collector/arbiter feeding CP0: forwards mtc0 writes,
// qualifies interrupts, picks one exception by priority and drives the flush.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        stall_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic        adel_if_i,
  input  logic        ri_i,
  input  logic        ov_i,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        eret_i,
  input  logic        load_i,
  input  logic        store_i,
  input  logic [1:0]  mem_size_i,
  input  logic [31:0] mem_addr_i,
  input  logic        cp0_we_i,
  input  logic [4:0]  cp0_waddr_i,
  input  logic [31:0] cp0_wdata_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  output logic        mem_kill_o,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] newpc_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  state_t r_state;

  logic [31:0] w_status;
  logic [31:0] w_cause;
  logic [31:0] w_epc;
  logic        w_int_pend;
  logic        w_mis;
  logic        w_detect;
  logic [31:0] w_code;
  logic [31:0] w_bad;

  // An mtc0 in the same cycle wins over the stale CP0 copy; only Cause[9:8] is software-writable.
  assign w_status = (cp0_we_i && cp0_waddr_i == CP0_STATUS) ? cp0_wdata_i : status_i;
  assign w_cause  = (cp0_we_i && cp0_waddr_i == CP0_CAUSE)
                  ? {cause_i[31:10], cp0_wdata_i[9:8], cause_i[7:0]} : cause_i;
  assign w_epc    = (cp0_we_i && cp0_waddr_i == CP0_EPC) ? cp0_wdata_i : epc_i;

  assign w_int_pend = w_status[0] & ~w_status[1] & (|(w_cause[15:8] & w_status[15:8]));

  assign w_mis = ((mem_size_i == 2'd1) & mem_addr_i[0]) |
                 ((mem_size_i == 2'd2) & (mem_addr_i[1:0] != 2'b00));

  assign w_detect = valid_i & (r_state == IDLE);

  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    w_code = 32'h0;
    w_bad  = 32'h0;
    if (w_int_pend)               w_code = 32'h01;
    else if (adel_if_i)         begin w_code = 32'h04; w_bad = pc_i;       end
    else if (ri_i)                w_code = 32'h0a;
    else if (ov_i)                w_code = 32'h0c;
    else if (syscall_i)           w_code = 32'h08;
    else if (break_i)             w_code = 32'h09;
    else if (load_i && w_mis)   begin w_code = 32'h04; w_bad = mem_addr_i; end
    else if (store_i && w_mis)  begin w_code = 32'h05; w_bad = mem_addr_i; end
    else if (eret_i)              w_code = 32'h0e;
  end

  assign mem_kill_o = w_detect & (w_code != 32'h0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state             <= IDLE;
      excepttype_o        <= 32'h0;
      current_inst_addr_o <= 32'h0;
      is_in_delayslot_o   <= 1'b0;
      bad_addr_o          <= 32'h0;
      flush_o             <= 1'b0;
      newpc_o             <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments keep all state updates on the same edge, order-independent.
      case (r_state)
        IDLE: begin
          if (w_detect && !stall_i && w_code != 32'h0) begin
            r_state             <= FLUSH;
            excepttype_o        <= w_code;
            current_inst_addr_o <= pc_i;
            is_in_delayslot_o   <= is_in_delayslot_i;
            bad_addr_o          <= w_bad;
            flush_o             <= 1'b1;
            newpc_o             <= (w_code == 32'h0e) ? w_epc : EXC_VECTOR;
          end else begin
            excepttype_o        <= 32'h0;
            current_inst_addr_o <= 32'h0;
            is_in_delayslot_o   <= 1'b0;
            bad_addr_o          <= 32'h0;
            flush_o             <= 1'b0;
            newpc_o             <= 32'h0;
          end
        end
        FLUSH: begin
          // The instruction now in MEM is being flushed, so nothing is detected here.
          r_state             <= IDLE;
          excepttype_o        <= 32'h0;
          current_inst_addr_o <= 32'h0;
          is_in_delayslot_o   <= 1'b0;
          bad_addr_o          <= 32'h0;
          flush_o             <= 1'b0;
          newpc_o             <= 32'h0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl with hand-computed expectations.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, stall_i, is_in_delayslot_i;
  logic [31:0] pc_i;
  logic        adel_if_i, ri_i, ov_i, syscall_i, break_i, eret_i;
  logic        load_i, store_i;
  logic [1:0]  mem_size_i;
  logic [31:0] mem_addr_i;
  logic        cp0_we_i;
  logic [4:0]  cp0_waddr_i;
  logic [31:0] cp0_wdata_i, status_i, cause_i, epc_i;
  logic        mem_kill_o, is_in_delayslot_o, flush_o;
  logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, newpc_o;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] VEC = 32'hBFC00380;

  exc_ctrl dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .stall_i(stall_i), .pc_i(pc_i),
    .is_in_delayslot_i(is_in_delayslot_i), .adel_if_i(adel_if_i), .ri_i(ri_i),
    .ov_i(ov_i), .syscall_i(syscall_i), .break_i(break_i), .eret_i(eret_i),
    .load_i(load_i), .store_i(store_i), .mem_size_i(mem_size_i),
    .mem_addr_i(mem_addr_i), .cp0_we_i(cp0_we_i), .cp0_waddr_i(cp0_waddr_i),
    .cp0_wdata_i(cp0_wdata_i), .status_i(status_i), .cause_i(cause_i),
    .epc_i(epc_i), .mem_kill_o(mem_kill_o), .excepttype_o(excepttype_o),
    .current_inst_addr_o(current_inst_addr_o), .is_in_delayslot_o(is_in_delayslot_o),
    .bad_addr_o(bad_addr_o), .flush_o(flush_o), .newpc_o(newpc_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic fl, input logic [31:0] exc,
                           input logic [31:0] pc, input logic ds, input logic [31:0] bad,
                           input logic [31:0] npc);
    check({tag, ".flush"}, {31'h0, flush_o}, {31'h0, fl});
    check({tag, ".exc"},   excepttype_o, exc);
    check({tag, ".pc"},    current_inst_addr_o, pc);
    check({tag, ".ds"},    {31'h0, is_in_delayslot_o}, {31'h0, ds});
    check({tag, ".bad"},   bad_addr_o, bad);
    check({tag, ".newpc"}, newpc_o, npc);
  endtask

  task automatic clear_inputs();
    valid_i = 0; stall_i = 0; is_in_delayslot_i = 0; pc_i = 0;
    adel_if_i = 0; ri_i = 0; ov_i = 0; syscall_i = 0; break_i = 0; eret_i = 0;
    load_i = 0; store_i = 0; mem_size_i = 0; mem_addr_i = 0;
    cp0_we_i = 0; cp0_waddr_i = 0; cp0_wdata_i = 0;
    status_i = 0; cause_i = 0; epc_i = 0;
  endtask

  // Drive on negedge, check the combinational kill, then sample registered outputs after posedge.
  task automatic step_kill(input string tag, input logic kill);
    #1 check({tag, ".kill"}, {31'h0, mem_kill_o}, {31'h0, kill});
    @(posedge clk); #1;
  endtask

  initial begin
    clear_inputs();
    rst = 0;
    @(posedge clk); @(posedge clk); #1;
    check_out("reset", 0, 0, 0, 0, 0, 0);

    // Misaligned word store
    @(negedge clk); rst = 1;
    valid_i = 1; store_i = 1; mem_size_i = 2; mem_addr_i = 32'h1002; pc_i = 32'h80001000;
    step_kill("ades", 1);
    check_out("ades_n1", 1, 32'h05, 32'h80001000, 0, 32'h1002, VEC);
    @(negedge clk); clear_inputs();
    step_kill("ades_flush", 0);
    check_out("ades_n2", 0, 0, 0, 0, 0, 0);

    // Aligned load: no exception
    @(negedge clk); valid_i = 1; load_i = 1; mem_size_i = 2; mem_addr_i = 32'h1004; pc_i = 32'h80001004;
    step_kill("aligned", 0);
    check_out("aligned", 0, 0, 0, 0, 0, 0);

    // Interrupt beats overflow
    @(negedge clk); clear_inputs();
    valid_i = 1; ov_i = 1; status_i = 32'h0000_0401; cause_i = 32'h0000_0400; pc_i = 32'h80001008;
    step_kill("int", 1);
    check_out("int", 1, 32'h01, 32'h80001008, 0, 0, VEC);
    @(negedge clk); status_i = 32'h0000_0403;
    step_kill("int_flush", 0);
    check({"int_flush", ".flush"}, {31'h0, flush_o}, 32'h0);
    // EXL set masks the interrupt, overflow wins
    step_kill("ov", 1);
    check_out("ov", 1, 32'h0c, 32'h80001008, 0, 0, VEC);
    @(negedge clk); clear_inputs();
    step_kill("ov_flush", 0);

    // Bubble with pending interrupt (forwarded Cause[8]), then taken on next valid
    @(negedge clk); status_i = 32'h0000_0101; cp0_we_i = 1; cp0_waddr_i = 13; cp0_wdata_i = 32'h100;
    step_kill("bubble", 0);
    check({"bubble", ".flush"}, {31'h0, flush_o}, 32'h0);
    @(negedge clk); valid_i = 1; pc_i = 32'h80001010;
    step_kill("fwd_int", 1);
    check_out("fwd_int", 1, 32'h01, 32'h80001010, 0, 0, VEC);
    @(negedge clk); clear_inputs();
    step_kill("fwd_flush", 0);

    // eret with same-cycle mtc0 to EPC
    @(negedge clk); valid_i = 1; eret_i = 1; pc_i = 32'h80001020; epc_i = 32'h80000100;
    cp0_we_i = 1; cp0_waddr_i = 14; cp0_wdata_i = 32'h80000200;
    step_kill("eret", 1);
    check_out("eret", 1, 32'h0e, 32'h80001020, 0, 0, 32'h80000200);
    @(negedge clk); clear_inputs();
    step_kill("eret_flush", 0);

    // Syscall held under stall
    @(negedge clk); valid_i = 1; syscall_i = 1; stall_i = 1; is_in_delayslot_i = 1; pc_i = 32'h80001030;
    for (int i = 0; i < 3; i++) begin
      step_kill("sys_stall", 1);
      check({"sys_stall", ".flush"}, {31'h0, flush_o}, 32'h0);
    end
    @(negedge clk); stall_i = 0;
    step_kill("sys", 1);
    check_out("sys", 1, 32'h08, 32'h80001030, 1, 0, VEC);
    @(negedge clk); clear_inputs();
    step_kill("sys_flush", 0);
    check_out("sys_n2", 0, 0, 0, 0, 0, 0);

    // Back-to-back: second fault arrives during FLUSH and is ignored
    @(negedge clk); valid_i = 1; ri_i = 1; pc_i = 32'h80001040;
    step_kill("ri", 1);
    check_out("ri", 1, 32'h0a, 32'h80001040, 0, 0, VEC);
    @(negedge clk); ri_i = 0; break_i = 1; pc_i = 32'h80001044;
    step_kill("brk_in_flush", 0);
    check_out("brk_in_flush", 0, 0, 0, 0, 0, 0);
    @(negedge clk); clear_inputs();
    step_kill("idle", 0);

    // Reset during FLUSH, then a new fault
    @(negedge clk); valid_i = 1; adel_if_i = 1; pc_i = 32'h80002001;
    step_kill("adel_if", 1);
    check_out("adel_if", 1, 32'h04, 32'h80002001, 0, 32'h80002001, VEC);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    check_out("rst_flush", 0, 0, 0, 0, 0, 0);
    // Fault still present while reset held: reset dominates capture
    @(posedge clk); #1;
    check_out("rst_hold", 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst = 1; clear_inputs();
    valid_i = 1; load_i = 1; mem_size_i = 1; mem_addr_i = 32'h2001; pc_i = 32'h80002010;
    step_kill("adel_ld", 1);
    check_out("adel_ld", 1, 32'h04, 32'h80002010, 0, 32'h2001, VEC);
    @(negedge clk); clear_inputs();
    step_kill("adel_flush", 0);
    check_out("adel_n2", 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
